// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared types and constants for the stopwatch / countdown timer.
//   state_t  : controller states
//   bcd_t    : one BCD digit
//   SEC_MAX  : highest seconds value (59)
//   DIGIT_W  : width of one BCD digit
//   bcd_inc  : two-digit BCD increment, wrapping to 00 above a limit
//   bcd_dec  : two-digit BCD decrement, wrapping to a limit below 00
// Both helpers return {wrap_flag, tens, ones}.
// ---------------------------------------------------------------------------
package timer_pkg;

    localparam int SEC_MAX = 59;
    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        PAUSE   = 3'd2,
        ADJUST  = 3'd3,
        EXPIRED = 3'd4
    } state_t;

    // Increment a BCD pair; at the limit it wraps to 00 and flags the carry.
    function automatic logic [2*DIGIT_W:0] bcd_inc(input bcd_t tens,
                                                   input bcd_t ones,
                                                   input bcd_t lim_tens,
                                                   input bcd_t lim_ones);
        if (tens == lim_tens && ones == lim_ones)
            return {1'b1, bcd_t'(0), bcd_t'(0)};
        else if (ones == bcd_t'(9))
            return {1'b0, bcd_t'(tens + bcd_t'(1)), bcd_t'(0)};
        else
            return {1'b0, tens, bcd_t'(ones + bcd_t'(1))};
    endfunction

    // Decrement a BCD pair; below 00 it wraps to the limit and flags the borrow.
    function automatic logic [2*DIGIT_W:0] bcd_dec(input bcd_t tens,
                                                   input bcd_t ones,
                                                   input bcd_t lim_tens,
                                                   input bcd_t lim_ones);
        if (tens == bcd_t'(0) && ones == bcd_t'(0))
            return {1'b1, lim_tens, lim_ones};
        else if (ones == bcd_t'(0))
            return {1'b0, bcd_t'(tens - bcd_t'(1)), bcd_t'(9)};
        else
            return {1'b0, tens, bcd_t'(ones - bcd_t'(1))};
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// ---------------------------------------------------------------------------
// timer_prescaler
// Divides the master clock into a 1 Hz tick and an adjust-rate tick.
// A synchronous clear restarts both dividers so that the first tick_1s
// arrives CLK_HZ cycles after the clearing edge.
// Ports:
//   clk      : master clock, rising edge
//   rst_n    : asynchronous active-low reset
//   clr      : synchronous restart of both dividers
//   tick_1s  : high for one cycle every CLK_HZ cycles
//   tick_adj : high for one cycle every CLK_HZ/ADJ_HZ cycles
// ---------------------------------------------------------------------------
module timer_prescaler #(
    parameter int CLK_HZ = 100000000,
    parameter int ADJ_HZ = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick_1s,
    output logic tick_adj
);

    localparam int ADJ_DIV = CLK_HZ / ADJ_HZ;
    localparam int SEC_W   = (CLK_HZ  > 1) ? $clog2(CLK_HZ)  : 1;
    localparam int ADJ_W   = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;

    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(CLK_HZ - 1);
    localparam logic [ADJ_W-1:0] ADJ_LAST = ADJ_W'(ADJ_DIV - 1);

    logic [SEC_W-1:0] sec_cnt;
    logic [ADJ_W-1:0] adj_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_cnt <= '0;
            adj_cnt <= '0;
        end else if (clr) begin
            sec_cnt <= '0;
            adj_cnt <= '0;
        end else begin
            sec_cnt <= (sec_cnt == SEC_LAST) ? '0 : sec_cnt + SEC_W'(1);
            adj_cnt <= (adj_cnt == ADJ_LAST) ? '0 : adj_cnt + ADJ_W'(1);
        end
    end

    assign tick_1s  = (sec_cnt == SEC_LAST);
    assign tick_adj = (adj_cnt == ADJ_LAST);

endmodule

// File: rtl/timer_core.sv
// ---------------------------------------------------------------------------
// timer_core
// MM:SS stopwatch / countdown timer with an adjust mode, held as BCD digits.
// Optional lap hold is compiled in when TIMER_LAP_EN is defined; without it
// the lap input is ignored and lap_held is tied low.
// Ports:
//   clk_100MHz : master clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start_stop : one-cycle pulse, toggles run / pause
//   clear      : one-cycle pulse, zeroes the time and returns to IDLE
//   lap        : one-cycle pulse, toggles the lap hold (TIMER_LAP_EN only)
//   adj        : level, selects adjust mode from IDLE/PAUSE
//   sel        : level, 1 = adjust seconds, 0 = adjust minutes
//   down       : level, count-down mode
//   digits     : {min_tens, min_ones, sec_tens, sec_ones}
//   running    : 1 while in RUN
//   expired    : 1 while in EXPIRED
//   lap_held   : 1 while the displayed time is frozen
//   wrap       : one-cycle pulse when an up-count rolls MAX_MIN:59 -> 00:00
// ---------------------------------------------------------------------------
module timer_core
    import timer_pkg::*;
#(
    parameter int CLK_HZ  = 100000000,
    parameter int ADJ_HZ  = 2,
    parameter int MAX_MIN = 99
) (
    input  logic        clk_100MHz,
    input  logic        reset_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    input  logic        adj,
    input  logic        sel,
    input  logic        down,
    output logic [15:0] digits,
    output logic        running,
    output logic        expired,
    output logic        lap_held,
    output logic        wrap
);

    localparam bcd_t SEC_T = bcd_t'(SEC_MAX / 10);
    localparam bcd_t SEC_O = bcd_t'(SEC_MAX % 10);
    localparam bcd_t MIN_T = bcd_t'(MAX_MIN / 10);
    localparam bcd_t MIN_O = bcd_t'(MAX_MIN % 10);

    state_t state_q, state_nx;
    bcd_t   sec_t_q, sec_o_q, min_t_q, min_o_q;
    bcd_t   sec_t_nx, sec_o_nx, min_t_nx, min_o_nx;
    logic   wrap_nx;
    logic   presc_clr;
    logic   tick_1s, tick_adj;
    logic   time_zero;

    logic   sinc_c, minc_c, sdec_b, mdec_b;
    bcd_t   sinc_t, sinc_o, minc_t, minc_o;
    bcd_t   sdec_t, sdec_o, mdec_t, mdec_o;
    logic [15:0] time_nx;

    timer_prescaler #(
        .CLK_HZ (CLK_HZ),
        .ADJ_HZ (ADJ_HZ)
    ) u_prescaler (
        .clk      (clk_100MHz),
        .rst_n    (reset_n),
        .clr      (presc_clr),
        .tick_1s  (tick_1s),
        .tick_adj (tick_adj)
    );

    assign {sinc_c, sinc_t, sinc_o} = bcd_inc(sec_t_q, sec_o_q, SEC_T, SEC_O);
    assign {minc_c, minc_t, minc_o} = bcd_inc(min_t_q, min_o_q, MIN_T, MIN_O);
    assign {sdec_b, sdec_t, sdec_o} = bcd_dec(sec_t_q, sec_o_q, SEC_T, SEC_O);
    assign {mdec_b, mdec_t, mdec_o} = bcd_dec(min_t_q, min_o_q, MIN_T, MIN_O);

    assign time_zero = (sec_t_q == '0) && (sec_o_q == '0) &&
                       (min_t_q == '0) && (min_o_q == '0);

`ifdef TIMER_LAP_EN
    logic        lap_held_q, lap_nx;
    logic [15:0] digits_q;
`endif

    always_comb begin
        state_nx  = state_q;
        sec_t_nx  = sec_t_q;
        sec_o_nx  = sec_o_q;
        min_t_nx  = min_t_q;
        min_o_nx  = min_o_q;
        wrap_nx   = 1'b0;
        presc_clr = 1'b0;
`ifdef TIMER_LAP_EN
        lap_nx    = lap_held_q;
`endif

        if (clear) begin
            // Clear outranks every other input and any coincident tick.
            state_nx  = IDLE;
            sec_t_nx  = '0;
            sec_o_nx  = '0;
            min_t_nx  = '0;
            min_o_nx  = '0;
            presc_clr = 1'b1;
`ifdef TIMER_LAP_EN
            lap_nx    = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (start_stop) begin
                        // A countdown from 00:00 would expire instantly; refuse it.
                        if (!(down && time_zero))
                            state_nx = RUN;
                    end else if (adj) begin
                        state_nx = ADJUST;
                    end
                end

                RUN: begin
                    if (tick_1s) begin
                        if (!down) begin
                            {sec_t_nx, sec_o_nx} = {sinc_t, sinc_o};
                            if (sinc_c) begin
                                {min_t_nx, min_o_nx} = {minc_t, minc_o};
                                wrap_nx = minc_c;
                            end
                        end else if (sdec_b && mdec_b) begin
                            // Already at 00:00 (down selected mid-run): stop there.
                            state_nx = EXPIRED;
                        end else begin
                            {sec_t_nx, sec_o_nx} = {sdec_t, sdec_o};
                            if (sdec_b)
                                {min_t_nx, min_o_nx} = {mdec_t, mdec_o};
                            if (sec_t_nx == '0 && sec_o_nx == '0 &&
                                min_t_nx == '0 && min_o_nx == '0)
                                state_nx = EXPIRED;
                        end
                    end
                    // The tick above still lands when start_stop arrives with it.
                    if (start_stop && state_nx == RUN)
                        state_nx = PAUSE;
                end

                ADJUST: begin
                    if (!adj) begin
                        state_nx = PAUSE;
                    end else if (tick_adj) begin
                        // Fields wrap independently; no carry between them.
                        if (sel)
                            {sec_t_nx, sec_o_nx} = {sinc_t, sinc_o};
                        else
                            {min_t_nx, min_o_nx} = {minc_t, minc_o};
                    end
                end

                EXPIRED: begin
                    if (start_stop)
                        state_nx = IDLE;
                end

                default: state_nx = IDLE;
            endcase

`ifdef TIMER_LAP_EN
            if (lap && (state_q == RUN || state_q == PAUSE))
                lap_nx = ~lap_held_q;
`endif

            // Restart the dividers so the first tick is a full period after entry.
            if ((state_nx == RUN    && state_q != RUN) ||
                (state_nx == ADJUST && state_q != ADJUST))
                presc_clr = 1'b1;
        end
    end

    assign time_nx = {min_t_nx, min_o_nx, sec_t_nx, sec_o_nx};

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sec_t_q <= '0;
            sec_o_q <= '0;
            min_t_q <= '0;
            min_o_q <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_nx;
            sec_t_q <= sec_t_nx;
            sec_o_q <= sec_o_nx;
            min_t_q <= min_t_nx;
            min_o_q <= min_o_nx;
            running <= (state_nx == RUN);
            expired <= (state_nx == EXPIRED);
            wrap    <= wrap_nx;
        end
    end

`ifdef TIMER_LAP_EN
    // The display register doubles as the lap capture: it follows the live
    // time except while a hold is already in force.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            lap_held_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            lap_held_q <= lap_nx;
            if (!(lap_nx && lap_held_q))
                digits_q <= time_nx;
        end
    end

    assign digits   = digits_q;
    assign lap_held = lap_held_q;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign digits     = {min_t_q, min_o_q, sec_t_q, sec_o_q};
    assign lap_held   = 1'b0;
`endif

endmodule

// File: tb/tb_timer_core.sv
// ---------------------------------------------------------------------------
// tb_timer_core
// Directed stimulus for timer_core with CLK_HZ=4, ADJ_HZ=2, MAX_MIN=1.
// Stimulus pushes expected {digits, running, expired, wrap, lap_held} with
// the cycle it is due into a scoreboard queue; a monitor on the falling
// edge pops and compares each entry when its cycle comes up.
// ---------------------------------------------------------------------------
module tb_timer_core;

    logic        clk = 1'b0;
    logic        reset_n, start_stop, clear, lap, adj, sel, down;
    logic [15:0] digits;
    logic        running, expired, lap_held, wrap;

    timer_core #(
        .CLK_HZ  (4),
        .ADJ_HZ  (2),
        .MAX_MIN (1)
    ) dut (
        .clk_100MHz (clk),
        .reset_n    (reset_n),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .adj        (adj),
        .sel        (sel),
        .down       (down),
        .digits     (digits),
        .running    (running),
        .expired    (expired),
        .lap_held   (lap_held),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        string       name;
        logic [19:0] exp;
    } item_t;

    item_t sb[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every scoreboard entry whose cycle has arrived.
    always @(negedge clk) begin
        item_t       it;
        logic [19:0] act;
        act = {digits, running, expired, wrap, lap_held};
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            checks++;
            if (it.due < cyc) begin
                errors++;
                $display("FAIL %s: slot missed (due cycle %0d, now %0d)", it.name, it.due, cyc);
            end else if (act !== it.exp) begin
                errors++;
                $display("FAIL %s: got digits=%h run=%b exp=%b wrap=%b lap=%b, want digits=%h run=%b exp=%b wrap=%b lap=%b",
                         it.name, act[19:4], act[3], act[2], act[1], act[0],
                         it.exp[19:4], it.exp[3], it.exp[2], it.exp[1], it.exp[0]);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic cl, input logic lp);
        start_stop = ss;
        clear      = cl;
        lap        = lp;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] d, input logic r,
                              input logic e, input logic w, input logic l);
        sb.push_back('{due: cyc, name: nm, exp: {d, r, e, w, l}});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
        adj = 1'b0; sel = 1'b0; down = 1'b0;

        step(2);
        expect_out("reset_state", 16'h0000, 0, 0, 0, 0);
        step(1);
        reset_n = 1'b1;
        step(2);
        expect_out("idle_after_reset", 16'h0000, 0, 0, 0, 0);

        // Up count: first tick exactly 4 cycles after RUN entry.
        pulse(1, 0, 0);
        expect_out("run_entry", 16'h0000, 1, 0, 0, 0);
        step(3);
        expect_out("pre_first_tick", 16'h0000, 1, 0, 0, 0);
        step(1);
        expect_out("first_tick", 16'h0001, 1, 0, 0, 0);
        step(236);
        expect_out("one_minute", 16'h0100, 1, 0, 0, 0);
        step(4);
        expect_out("one_min_one_sec", 16'h0101, 1, 0, 0, 0);

        // Wrap at MAX_MIN:59.
        step(232);
        expect_out("at_max", 16'h0159, 1, 0, 0, 0);
        step(3);
        expect_out("pre_wrap", 16'h0159, 1, 0, 0, 0);
        step(1);
        expect_out("wrap_pulse", 16'h0000, 1, 0, 1, 0);
        step(1);
        expect_out("wrap_one_cycle", 16'h0000, 1, 0, 0, 0);

        // start_stop landing on a tick edge: tick applied, then pause.
        step(2);
        pulse(1, 0, 0);
        expect_out("stop_on_tick", 16'h0001, 0, 0, 0, 0);
        step(8);
        expect_out("pause_holds", 16'h0001, 0, 0, 0, 0);

        // Adjust seconds, then minutes.
        sel = 1'b1; adj = 1'b1;
        step(1);
        expect_out("adj_entry", 16'h0001, 0, 0, 0, 0);
        step(114);
        expect_out("adj_sec_58", 16'h0058, 0, 0, 0, 0);
        step(2);
        expect_out("adj_sec_59", 16'h0059, 0, 0, 0, 0);
        step(2);
        expect_out("adj_sec_wrap_no_carry", 16'h0000, 0, 0, 0, 0);
        step(2);
        expect_out("adj_sec_01", 16'h0001, 0, 0, 0, 0);
        sel = 1'b0;
        step(2);
        expect_out("adj_min_inc", 16'h0101, 0, 0, 0, 0);
        step(2);
        expect_out("adj_min_wrap", 16'h0001, 0, 0, 0, 0);
        adj = 1'b0;
        step(1);
        expect_out("adj_exit", 16'h0001, 0, 0, 0, 0);
        step(4);
        expect_out("pause_after_adj", 16'h0001, 0, 0, 0, 0);

        // clear + start_stop together on a tick edge while running at 00:37.
        pulse(1, 0, 0);
        expect_out("resume", 16'h0001, 1, 0, 0, 0);
        step(144);
        expect_out("at_37", 16'h0037, 1, 0, 0, 0);
        step(3);
        expect_out("still_37", 16'h0037, 1, 0, 0, 0);
        pulse(1, 1, 0);
        expect_out("clear_wins", 16'h0000, 0, 0, 0, 0);
        step(4);
        expect_out("idle_hold", 16'h0000, 0, 0, 0, 0);

        // Down mode: refused at 00:00, then count 00:02 to expiry.
        down = 1'b1;
        pulse(1, 0, 0);
        expect_out("down_zero_refused", 16'h0000, 0, 0, 0, 0);
        sel = 1'b1; adj = 1'b1;
        step(1);
        step(4);
        expect_out("set_00_02", 16'h0002, 0, 0, 0, 0);
        adj = 1'b0;
        step(1);
        expect_out("paused_00_02", 16'h0002, 0, 0, 0, 0);
        pulse(1, 0, 0);
        expect_out("down_run", 16'h0002, 1, 0, 0, 0);
        step(4);
        expect_out("down_00_01", 16'h0001, 1, 0, 0, 0);
        step(4);
        expect_out("expired", 16'h0000, 0, 1, 0, 0);
        step(4);
        expect_out("expired_holds", 16'h0000, 0, 1, 0, 0);
        pulse(1, 0, 0);
        expect_out("expired_exit", 16'h0000, 0, 0, 0, 0);

        // Lap hold.
        down = 1'b0;
        pulse(1, 0, 0);
        step(20);
        expect_out("lap_pre", 16'h0005, 1, 0, 0, 0);
        pulse(0, 0, 1);
`ifdef TIMER_LAP_EN
        expect_out("lap_capture", 16'h0005, 1, 0, 0, 1);
        step(12);
        expect_out("lap_frozen", 16'h0005, 1, 0, 0, 1);
        pulse(0, 0, 1);
        expect_out("lap_release", 16'h0008, 1, 0, 0, 0);
`else
        expect_out("lap_ignored", 16'h0005, 1, 0, 0, 0);
        step(12);
        expect_out("lap_live", 16'h0008, 1, 0, 0, 0);
        pulse(0, 0, 1);
        expect_out("lap_ignored_2", 16'h0008, 1, 0, 0, 0);
`endif

        // Asynchronous reset mid-run, checked before the next clock edge.
        step(1);
        reset_n = 1'b0;
        expect_out("reset_async", 16'h0000, 0, 0, 0, 0);
        step(3);
        expect_out("reset_held", 16'h0000, 0, 0, 0, 0);
        reset_n = 1'b1;
        step(6);
        expect_out("post_reset_idle", 16'h0000, 0, 0, 0, 0);

        step(2);
        while (sb.size() > 0) begin
            item_t it;
            it = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: never compared (due cycle %0d)", it.name, it.due);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_core.md
TIMER_CORE -- requirements
Module: timer_core

Interface
REQ-001 Parameter CLK_HZ, default 100000000, master clock frequency in Hz.
REQ-002 Parameter ADJ_HZ, default 2, adjust-mode increment rate in Hz; CLK_HZ SHALL be an integer multiple of ADJ_HZ.
REQ-003 Parameter MAX_MIN, default 99, highest minutes value, range 1..99.
REQ-004 clk_100MHz  input  1  single clock, rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start_stop  input  1  debounced one-cycle pulse that toggles run/pause.
REQ-007 clear  input  1  debounced one-cycle pulse that zeroes the time.
REQ-008 lap  input  1  debounced one-cycle pulse that toggles the lap hold.
REQ-009 adj, sel, down  input  1 each  levels: adj = adjust mode; sel = 1 selects seconds, 0 selects minutes; down = count-down mode.
REQ-010 digits  output  16  BCD {min_tens, min_ones, sec_tens, sec_ones}.
REQ-011 running, expired, lap_held  output  1 each  status levels; wrap  output  1  one-cycle pulse.

Function
REQ-012 The state machine SHALL have these states: IDLE, RUN, PAUSE, ADJUST, EXPIRED.
REQ-013 The prescaler SHALL emit tick_1s every CLK_HZ cycles and tick_adj every CLK_HZ/ADJ_HZ cycles, with the first tick CLK_HZ cycles after RUN entry.
REQ-014 The prescaler SHALL be cleared on any entry to RUN or ADJUST.
REQ-015 IDLE/PAUSE + start_stop -> RUN, except in down mode with time 00:00, where the state SHALL stay unchanged.
REQ-016 RUN + start_stop -> PAUSE.
REQ-017 IDLE/PAUSE + adj=1 -> ADJUST; ADJUST + adj=0 -> PAUSE; adj SHALL be ignored in RUN and EXPIRED.
REQ-018 RUN up-count on tick_1s: seconds 59 -> 00 SHALL carry into minutes; MAX_MIN:59 -> 00:00 SHALL pulse wrap for 1 cycle and keep running.
REQ-019 RUN down-count on tick_1s: seconds 00 -> 59 SHALL borrow from minutes; reaching 00:00 SHALL enter EXPIRED on the same edge and set expired=1.
REQ-020 ADJUST on tick_adj SHALL increment only the selected field: seconds wrap 59 -> 00 with no carry; minutes wrap MAX_MIN -> 00.
REQ-021 A change of sel in ADJUST SHALL take effect from the next tick_adj without clearing the prescaler.
REQ-022 EXPIRED SHALL hold at 00:00; clear or start_stop SHALL leave EXPIRED -> IDLE and drop expired.
REQ-023 clear in any state SHALL set the time to 00:00, go to IDLE, release the lap hold and clear the prescaler.
REQ-024 clear SHALL have priority over start_stop, lap and a same-cycle tick.
REQ-025 start_stop coincident with tick_1s in RUN: the tick SHALL be applied and the state SHALL go to PAUSE on the same edge.
REQ-026 running SHALL be 1 exactly in RUN; all outputs SHALL be registered with 1-cycle latency from the causing edge.
REQ-027 The time SHALL be held internally as BCD digits; no binary-to-BCD conversion is permitted.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, time 00:00, prescaler 0 and digits=16'h0000.
REQ-029 reset_n low SHALL asynchronously force running=0, expired=0, lap_held=0 and wrap=0.
REQ-030 Deassertion of reset_n SHALL be taken synchronously, with the first count CLK_HZ cycles after a RUN entry.
REQ-031 Reset asserted mid-count SHALL discard all state, with no residual tick or wrap pulse.

Configuration
REQ-032 With TIMER_LAP_EN defined, lap in RUN or PAUSE SHALL toggle lap_held.
REQ-033 With TIMER_LAP_EN defined, while lap_held=1 digits SHALL freeze at the value captured on the lap edge and counting SHALL continue.
REQ-034 With TIMER_LAP_EN defined, release of the hold SHALL show the live time on the next cycle; lap SHALL be ignored in IDLE, ADJUST and EXPIRED.
REQ-035 Without TIMER_LAP_EN, the lap input SHALL be ignored, lap_held SHALL be tied to 0, digits SHALL always show the live time, and no capture register SHALL be synthesised.

Structure
REQ-036 Package timer_pkg SHALL hold the state enum, the BCD digit type and the constants SEC_MAX=59 and DIGIT_W=4.
REQ-037 One sub-module, timer_prescaler, SHALL be instantiated; it is parametrised by CLK_HZ and ADJ_HZ, has a synchronous clear input and outputs tick_1s and tick_adj.

Verification (CLK_HZ=4, ADJ_HZ=2, MAX_MIN=1)
REQ-038 Up mode, start_stop, 240 cycles -> digits 16'h0100; 4 more cycles -> 16'h0101.
REQ-039 Up mode from 01:59 + 1 tick -> digits 16'h0000, wrap high for exactly 1 cycle, running=1.
REQ-040 Down mode, time 00:02, start_stop -> digits 16'h0001 after 4 cycles, then 16'h0000, expired=1 and state EXPIRED after 8 cycles.
REQ-041 PAUSE, adj=1, sel=1, 120 cycles starting at 00:58 -> seconds sequence 59, 00, 01... with minutes unchanged; adj=0 -> PAUSE.
REQ-042 clear and start_stop in the same cycle while in RUN at 00:37 -> 16'h0000 and IDLE; reset_n low mid-RUN -> all outputs 0 asynchronously.
REQ-043 TIMER_LAP_EN defined, lap at 00:05 -> digits hold 16'h0005 while the internal count runs for 12 cycles; second lap -> 16'h0008.
